// File: rtl/memory_address_unit_buffered_if.sv
// Handshake/bus bundle between the memory reservation station, the address unit and the
// downstream load/store buffers. "master" is the environment side, "slave" is the unit.
interface memory_address_unit_buffered_if #(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned ROB_TAG_WIDTH = 5
);
  // Issue side (from the reservation station)
  logic [XLEN-1:0]          base;
  logic [XLEN-1:0]          offset;
  logic [ROB_TAG_WIDTH-1:0] rob_tag_in;
  logic [1:0]               size;
  logic                     is_store_in;
  logic                     ready_to_execute;
  logic                     accept;

  // Result side (to the load/store buffers)
  logic                     buffer_ready;
  logic                     write_to_buffer;
  logic [XLEN-1:0]          result;
  logic [ROB_TAG_WIDTH-1:0] rob_tag_out;
  logic                     is_store_out;
  logic                     misaligned;

  modport master (
    output base, offset, rob_tag_in, size, is_store_in, ready_to_execute, buffer_ready,
    input  accept, write_to_buffer, result, rob_tag_out, is_store_out, misaligned
  );

  modport slave (
    input  base, offset, rob_tag_in, size, is_store_in, ready_to_execute, buffer_ready,
    output accept, write_to_buffer, result, rob_tag_out, is_store_out, misaligned
  );
endinterface

// File: rtl/memory_address_unit_buffered.sv
// Load/store effective-address generation with misalignment detection and a small result
// FIFO drained towards the load/store buffers under a valid/ready handshake.
module memory_address_unit_buffered #(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned ROB_TAG_WIDTH = 5,
  parameter int unsigned BUF_DEPTH     = 2
) (
  input logic                          clk,
  input logic                          reset,
  input logic                          flush,
  memory_address_unit_buffered_if.slave bus
);

  localparam int unsigned PtrW = $clog2(BUF_DEPTH);
  localparam int unsigned CntW = $clog2(BUF_DEPTH + 1);

  // FIFO storage
  logic [XLEN-1:0]          addr_mem [BUF_DEPTH];
  logic [ROB_TAG_WIDTH-1:0] tag_mem  [BUF_DEPTH];
  logic                     st_mem   [BUF_DEPTH];
  logic                     mis_mem  [BUF_DEPTH];

  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic            push, pop, empty;
  logic [XLEN-1:0] eff_addr;
  logic            eff_mis;

  // Carry-out of the sum is intentionally dropped (address wraps mod 2^XLEN)
  assign eff_addr = bus.base + bus.offset;
  assign empty    = (count_q == '0);

  // No pass-through: a full FIFO refuses a push even if it pops this cycle
  assign push = bus.ready_to_execute & ~flush & (count_q < CntW'(BUF_DEPTH));
  assign pop  = ~empty & bus.buffer_ready & ~flush;

  assign bus.accept          = push;
  assign bus.write_to_buffer = pop;

  // Alignment check on the computed address; illegal size is always flagged
  always_comb begin
    eff_mis = 1'b0;
    unique case (bus.size)
      2'b00:   eff_mis = 1'b0;
      2'b01:   eff_mis = eff_addr[0];
      2'b10:   eff_mis = (eff_addr[1:0] != 2'b00);
      default: eff_mis = 1'b1;
    endcase
  end

  // Head entry drives the outputs; all zero while empty
  always_comb begin
    bus.result       = '0;
    bus.rob_tag_out  = '0;
    bus.is_store_out = 1'b0;
    bus.misaligned   = 1'b0;
    if (!empty) begin
      bus.result       = addr_mem[rd_ptr_q];
      bus.rob_tag_out  = tag_mem[rd_ptr_q];
      bus.is_store_out = st_mem[rd_ptr_q];
      bus.misaligned   = mis_mem[rd_ptr_q];
    end
  end

  // Pointer/occupancy next state; power-of-2 depth lets pointers wrap naturally
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (push && !pop)      count_d = count_q + CntW'(1);
    else if (pop && !push) count_d = count_q - CntW'(1);
  end

  // Control state; reset beats flush, flush discards this cycle's push/pop
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry write; contents are don't-care until occupancy says otherwise
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= eff_addr;
      tag_mem[wr_ptr_q]  <= bus.rob_tag_in;
      st_mem[wr_ptr_q]   <= bus.is_store_in;
      mis_mem[wr_ptr_q]  <= eff_mis;
    end
  end

endmodule
